// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle sequencer: FSM states, instruction classes,
// opcode/funct constants and exception cause codes.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ALU,
    CLS_ALU_OV,
    CLS_LOAD,
    CLS_STORE,
    CLS_BEQ,
    CLS_J,
    CLS_JAL,
    CLS_JR,
    CLS_ILL
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] CAUSE_OVF = 2'd0;
  localparam logic [1:0] CAUSE_ILL = 2'd1;
  localparam logic [1:0] CAUSE_BUS = 2'd2;

endpackage

// File: rtl/mc_seq_if.sv
// Instruction/data memory handshake bundle; the sequencer is the master side.
interface mc_seq_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (output imem_req, dmem_req, dmem_we, input imem_ready, dmem_ready);
  modport slave  (input imem_req, dmem_req, dmem_we, output imem_ready, dmem_ready);
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; anything outside the decoded set is CLS_ILL.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_e       cls,
  output logic       legal
);

  always_comb begin
    cls = CLS_ILL;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:                  cls = CLS_ALU_OV;
          FN_ADDU, FN_SUBU, FN_SLT: cls = CLS_ALU;
          FN_JR:                   cls = CLS_JR;
          default:                 cls = CLS_ILL;
        endcase
      end
      OP_ADDI:                    cls = CLS_ALU_OV;
      OP_ADDIU, OP_ORI, OP_LUI:   cls = CLS_ALU;
      OP_LW, OP_LB:               cls = CLS_LOAD;
      OP_SW, OP_SB:               cls = CLS_STORE;
      OP_BEQ:                     cls = CLS_BEQ;
      OP_J:                       cls = CLS_J;
      OP_JAL:                     cls = CLS_JAL;
      default:                    cls = CLS_ILL;
    endcase
  end

  assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/mc_seq.sv
// Multicycle CPU control sequencer (FETCH/DECODE/EXEC/MEM/WB/EXC).
// Optional MC_SEQ_EXC_EN adds overflow/illegal/bus-timeout exceptions.
module mc_seq
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  mc_seq_if.master         mem,
  output logic [2:0]       state,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             gpr_wr,
  output logic             branch,
  output logic             jump,
  output logic             jr,
  output logic             link,
  output logic             exc,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired
);

`ifdef MC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  cls_e              cls;
  logic              legal;
  logic              stall;
  logic              wait_hit;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls),
    .legal  (legal)
  );

  assign stall    = ((state_q == ST_FETCH) && !mem.imem_ready) ||
                    ((state_q == ST_MEM)   && !mem.dmem_ready);
  assign wait_hit = EXC_EN && stall && (wait_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    gpr_wr       = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
    link         = 1'b0;
    exc          = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_FETCH: begin
          mem.imem_req = 1'b1;
          if (mem.imem_ready) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_hit) begin
            state_d = ST_EXC;
            cause_d = CAUSE_BUS;
          end
        end
        ST_DECODE: begin
          if (EXC_EN && !legal) begin
            state_d = ST_EXC;
            cause_d = CAUSE_ILL;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_d = ST_FETCH;
          unique case (cls)
            CLS_ALU:    state_d = ST_WB;
            CLS_ALU_OV: begin
              if (EXC_EN && overflow) begin
                state_d = ST_EXC;
                cause_d = CAUSE_OVF;
              end else begin
                state_d = ST_WB;
              end
            end
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_BEQ: begin
              branch = 1'b1;
              pc_wr  = zero;
            end
            CLS_J: begin
              jump  = 1'b1;
              pc_wr = 1'b1;
            end
            CLS_JR: begin
              jr    = 1'b1;
              pc_wr = 1'b1;
            end
            CLS_JAL: begin
              jump   = 1'b1;
              link   = 1'b1;
              gpr_wr = 1'b1;
              pc_wr  = 1'b1;
            end
            default: state_d = ST_FETCH;  // illegal retires as a NOP
          endcase
        end
        ST_MEM: begin
          mem.dmem_req = 1'b1;
          mem.dmem_we  = (cls == CLS_STORE);
          if (mem.dmem_ready) begin
            state_d = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
          end else if (wait_hit) begin
            state_d = ST_EXC;
            cause_d = CAUSE_BUS;
          end
        end
        ST_WB: begin
          gpr_wr  = 1'b1;
          state_d = ST_FETCH;
        end
        ST_EXC: begin
          exc     = EXC_EN;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // Wait counter restarts on any state change and saturates when unbounded.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (stall && (wait_q != {TO_W{1'b1}})) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_comb begin
    retired_d = retired_q;
    if ((state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_EXC)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      cause_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign state     = state_q;
  assign exc_cause = EXC_EN ? cause_q : 2'b00;
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_seq.sv
// Self-checking bench for mc_seq: per-instruction cycle/pulse totals versus a
// table-driven instruction model; honours MC_SEQ_EXC_EN when defined.
module tb_mc_seq;

`ifdef MC_SEQ_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif
  localparam int TIMEOUT = 15;

  localparam int K_ALU = 0, K_OV = 1, K_LD = 2, K_ST = 3, K_BEQ = 4,
                 K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

  typedef struct {
    int cyc; int gpr; int pc; int ir; int dreq; int dwe;
    int br; int jmp; int jrc; int lnk; int exc; int cause; int ret;
  } res_t;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        zero, overflow;
  logic [2:0]  state;
  logic        ir_wr, pc_wr, gpr_wr, branch, jump, jr, link, exc;
  logic [1:0]  exc_cause;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;
  int exp_retired = 0;

  mc_seq_if mif ();

  mc_seq #(.TIMEOUT(TIMEOUT), .TO_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem(mif.master), .state(state), .ir_wr(ir_wr),
    .pc_wr(pc_wr), .gpr_wr(gpr_wr), .branch(branch), .jump(jump), .jr(jr),
    .link(link), .exc(exc), .exc_cause(exc_cause), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h20) return K_OV;
      if (fn == 6'h21 || fn == 6'h23 || fn == 6'h2A) return K_ALU;
      if (fn == 6'h08) return K_JR;
      return K_ILL;
    end
    case (op)
      6'h08:               return K_OV;
      6'h09, 6'h0D, 6'h0F: return K_ALU;
      6'h23, 6'h20:        return K_LD;
      6'h2B, 6'h28:        return K_ST;
      6'h04:               return K_BEQ;
      6'h02:               return K_J;
      6'h03:               return K_JAL;
      default:             return K_ILL;
    endcase
  endfunction

  // Totals over one instruction from its first FETCH cycle to its return to FETCH.
  function automatic res_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input int idl, input int ddl, input logic z, input logic ov);
    res_t e;
    int k;
    e = '{default: 0};
    k = classify(op, fn);
    if (EXC_ON && idl >= TIMEOUT) begin
      e.cyc = TIMEOUT + 1; e.exc = 1; e.cause = 2;
      return e;
    end
    e.cyc = idl + 1; e.pc = 1; e.ir = 1;
    if (EXC_ON && k == K_ILL) begin
      e.cyc += 2; e.exc = 1; e.cause = 1;
      return e;
    end
    e.ret = 1;
    case (k)
      K_ALU: begin e.cyc += 3; e.gpr = 1; end
      K_OV: begin
        e.cyc += 3;
        if (EXC_ON && ov) begin e.exc = 1; e.cause = 0; e.ret = 0; end
        else e.gpr = 1;
      end
      K_LD:  begin e.cyc += 3 + ddl + 1; e.dreq = ddl + 1; e.gpr = 1; end
      K_ST:  begin e.cyc += 3 + ddl; e.dreq = ddl + 1; e.dwe = ddl + 1; end
      K_BEQ: begin e.cyc += 2; e.br = 1; e.pc += int'(z); end
      K_J:   begin e.cyc += 2; e.jmp = 1; e.pc += 1; end
      K_JAL: begin e.cyc += 2; e.jmp = 1; e.lnk = 1; e.gpr = 1; e.pc += 1; end
      K_JR:  begin e.cyc += 2; e.jrc = 1; e.pc += 1; end
      default: e.cyc += 2;
    endcase
    return e;
  endfunction

  // Entered and left at a negedge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int idl, input int ddl, input logic z, input logic ov);
    res_t e, o;
    int fw, mw;
    bit left, seen_cause;
    logic [1:0] cause_seen;
    e = model(op, fn, idl, ddl, z, ov);
    o = '{default: 0};
    fw = 0; mw = 0; left = 0; seen_cause = 0; cause_seen = 2'b00;
    opcode = op; funct = fn; zero = z; overflow = ov;
    while (1) begin
      mif.imem_ready = (state == 3'd0) ? (fw == idl) : 1'($urandom_range(1));
      mif.dmem_ready = (state == 3'd3) ? (mw == ddl) : 1'($urandom_range(1));
      #1;
      o.gpr += int'(gpr_wr); o.pc += int'(pc_wr); o.ir += int'(ir_wr);
      o.dreq += int'(mif.dmem_req); o.dwe += int'(mif.dmem_we);
      o.br += int'(branch); o.jmp += int'(jump); o.jrc += int'(jr);
      o.lnk += int'(link); o.exc += int'(exc);
      if (exc) begin seen_cause = 1; cause_seen = exc_cause; end
      if (state == 3'd0) fw++;
      if (state == 3'd3) mw++;
      o.cyc++;
      @(posedge clk);
      @(negedge clk);
      if (state != 3'd0) left = 1;
      else if (left) break;
      if (o.cyc > 200) begin
        chk({name, "_bound"}, o.cyc, e.cyc);
        break;
      end
    end
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    exp_retired += e.ret;
    chk({name, "_cycles"}, o.cyc, e.cyc);
    chk({name, "_gpr_wr"}, o.gpr, e.gpr);
    chk({name, "_pc_wr"}, o.pc, e.pc);
    chk({name, "_ir_wr"}, o.ir, e.ir);
    chk({name, "_dmem_req"}, o.dreq, e.dreq);
    chk({name, "_dmem_we"}, o.dwe, e.dwe);
    chk({name, "_branch"}, o.br, e.br);
    chk({name, "_jump"}, o.jmp, e.jmp);
    chk({name, "_jr"}, o.jrc, e.jrc);
    chk({name, "_link"}, o.lnk, e.lnk);
    chk({name, "_exc"}, o.exc, e.exc);
    if (seen_cause) chk({name, "_cause"}, cause_seen, e.cause);
    chk({name, "_retired"}, retired, exp_retired);
  endtask

  logic [5:0] pool_op [0:19];
  logic [5:0] pool_fn [0:19];

  initial begin
    pool_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23,
                6'h20, 6'h2B, 6'h28, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00, 6'h11, 6'h00};
    pool_fn = '{6'h20, 6'h21, 6'h23, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h21};
    rst = 1'b1; opcode = 6'h00; funct = 6'h21; zero = 1'b0; overflow = 1'b0;
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_imem_req", mif.imem_req, 0);
    chk("rst_dmem_req", mif.dmem_req, 0);
    chk("rst_pc_wr", pc_wr, 0);
    chk("rst_exc_cause", exc_cause, 0);
    chk("rst_retired", retired, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", mif.imem_req, 1);
    @(negedge clk);

    run_instr("addu", 6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
    run_instr("lw_d3", 6'h23, 6'h00, 0, 3, 1'b0, 1'b0);
    run_instr("beq_z1", 6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
    run_instr("beq_z0", 6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("jal", 6'h03, 6'h00, 2, 0, 1'b0, 1'b0);
    run_instr("add_ovf", 6'h00, 6'h20, 0, 0, 1'b0, 1'b1);
    run_instr("addi_ovf", 6'h08, 6'h00, 1, 0, 1'b0, 1'b1);
    run_instr("op3f", 6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    run_instr("sw_d2", 6'h2B, 6'h00, 1, 2, 1'b0, 1'b0);

`ifdef MC_SEQ_EXC_EN
    run_instr("fetch_timeout", 6'h00, 6'h21, 20, 0, 1'b0, 1'b0);
`else
    mif.imem_ready = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("stall_state", state, 0);
    chk("stall_imem_req", mif.imem_req, 1);
    chk("stall_exc", exc, 0);
    @(negedge clk);
    run_instr("after_stall", 6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      int idx;
      idx = int'($urandom_range(19));
      run_instr($sformatf("rnd%0d", i), pool_op[idx], pool_fn[idx],
                int'($urandom_range(5)), int'($urandom_range(5)),
                1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Reset while a store is waiting on dmem_ready.
    opcode = 6'h2B; funct = 6'h00;
    for (int n = 0; n < 20 && state != 3'd3; n++) begin
      mif.imem_ready = (state == 3'd0);
      @(negedge clk);
    end
    mif.imem_ready = 1'b0;
    chk("sw_reached_mem", state, 3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mem_rst_state", state, 0);
    chk("mem_rst_dmem_req", mif.dmem_req, 0);
    chk("mem_rst_retired", retired, 0);
    rst = 1'b0;
    #1;
    chk("mem_rst_imem_req", mif.imem_req, 1);
    exp_retired = 0;
    @(negedge clk);
    run_instr("post_rst_ori", 6'h0D, 6'h00, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
